seg7_scan_display: RTL and testbench
====================================

// Module: seg7_scan_display
// PURPOSE
//  Display back-end of the CPU top level. Selects one 32-bit word from four CPU status words
//  (LED data, total cycles, branch count, jump count) using Show.
//  Drives it as 8 hex digits on the multiplexed, active-low 7-segment display (SEG/AN).
//  Snapshots the word once per scan frame so a digit never tears mid-frame.
// PARAMETERS
//  SCAN_DIV  100000  clk cycles per digit slot (>=2); use 4 in simulation
//  BLANK_LZ  0       1 = blank leading-zero digits (digit 0 always lit)
// PORTS
//  clk           in   1   system clock; single clock domain
//  clr           in   1   synchronous, active-high reset
//  Show          in   3   source select: 0 Leddata, 1 countAll, 2 Count_branch, 3 countJmp, 4-7 invalid
//  Leddata       in   32  syscall/LED output word
//  countAll      in   32  total executed-cycle counter
//  Count_branch  in   32  taken-branch counter
//  countJmp      in   32  jump counter
//  SEG           out  8   [6:0]=g..a, [7]=dp; active low, registered
//  AN            out  8   digit enables, AN[i] low = digit i lit, registered
//  frame_tick    out  1   1-cycle pulse when a new snapshot is taken
// BEHAVIOUR
//  Reset (clr=1 at posedge) sets:
//   - div_cnt=0, digit=0, shadow=32'h0, frame_tick=0
//   - AN=8'hFE, SEG=8'hC0 ('0' on digit 0)
//   - All other state cleared in the same cycle. Reset mid-frame aborts the frame; no partial state survives.
//  Divider:
//   - div_cnt counts 0..SCAN_DIV-1 and wraps to 0.
//   - slot_end = (div_cnt==SCAN_DIV-1).
//  Digit index:
//   - digit (3 bits) increments on slot_end and wraps 7->0.
//  Snapshot:
//   - On the slot_end edge where digit==7, shadow <= word selected by the Show sampled that cycle.
//   - frame_tick=1 for the following cycle only.
//   - Show or source changes at any other time affect nothing until the next snapshot.
//  Invalid Show (4-7):
//   - shadow is loaded with 0. Its invalid flag is stored beside it in shadow_inv.
//   - While shadow_inv=1, all digits show a dash: SEG=8'hBF, dp off.
//  Output latency:
//   - AN/SEG are registered from (digit, shadow), so they lag digit by exactly 1 cycle.
//   - The first cycle of a slot still shows the previous digit. This is accepted; no blanking guard.
//  AN:
//   - AN = ~(8'b1 << digit), exactly one digit low.
//   - Exception, BLANK_LZ=1: digit i>0 is blanked (AN all ones for that slot) when shadow[31:4*i]==0.
//  SEG:
//   - Hex decode of shadow[4*digit+3:4*digit], active low:
//     0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E
//   - SEG[7] (dp) is always 1 (off).
//  Simultaneous events:
//   - clr overrides everything.
//   - The snapshot and the digit 7->0 wrap occur on the same edge.
//   - Digit 0 of the new frame shows the new shadow.
//  Widths:
//   - div_cnt is $clog2(SCAN_DIV) bits and never exceeds SCAN_DIV-1.
// STRUCTURE
//  Shared package/header:
//   - Show select codes (SHOW_LED, SHOW_ALL, SHOW_BR, SHOW_JMP)
//   - SEG_DASH=8'hBF, SEG_BLANK=8'hFF
//   - Hex segment table
//  Sub-module seg7_decode: combinational 4-bit nibble -> 8-bit active-low pattern. It is instantiated once.
//  The top holds:
//   - divider
//   - digit counter
//   - snapshot mux/register
//   - leading-zero compare
//   - output registers
// TESTING (SCAN_DIV=4)
//  1. Reset: clr=1 for 2 cycles, release -> AN=FE, SEG=C0, frame_tick=0.
//     The first snapshot frame_tick appears 32 cycles after release.
//  2. Show=0, Leddata=32'h1234ABCD:
//     - after the first snapshot, SEG per digit 0..7 = A1,C6,83,88,99,B0,A4,F9
//     - AN walks FE,FD,...,7F, each held 4 cycles
//  3. Tear-free: change countAll 32'h0 -> 32'hFFFFFFFF while digit=3 with Show=1.
//     - digits 4-7 of the current frame stay C0
//     - all digits show 8E only after the next frame_tick
//  4. Invalid select: Show=5 -> after the next snapshot all 8 digits show SEG=BF.
//     Show=2 -> decode resumes next frame.
//  5. BLANK_LZ=1, countJmp=32'h00000050:
//     - digits 0 and 1 lit (C0, 92)
//     - slots for digits 2-7 drive AN=FF
//     countJmp=0 -> only digit 0 lit, showing C0.
//  6. Mid-frame reset: assert clr at digit=5 -> next cycle AN=FE, SEG=C0, shadow=0. The frame restarts from digit 0.

Source files
------------

// File: rtl/seg7_scan_display_pkg.sv
// Shared definitions for the multiplexed 7-segment status display:
// source select codes, special segment patterns and the hex segment table.
package seg7_scan_display_pkg;

  typedef enum logic [2:0] {
    SHOW_LED = 3'd0,
    SHOW_ALL = 3'd1,
    SHOW_BR  = 3'd2,
    SHOW_JMP = 3'd3
  } show_e;

  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low patterns, bit 7 is the decimal point and always stays off.
  function automatic logic [7:0] hex_seg(input logic [3:0] nibble);
    logic [7:0] seg;
    case (nibble)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_scan_display_if.sv
// Status-word inputs and display outputs of the scan display, grouped as one bus.
interface seg7_scan_display_if;
  logic [2:0]  Show;
  logic [31:0] Leddata;
  logic [31:0] countAll;
  logic [31:0] Count_branch;
  logic [31:0] countJmp;
  logic [7:0]  SEG;
  logic [7:0]  AN;
  logic        frame_tick;

  modport master (
    output Show, Leddata, countAll, Count_branch, countJmp,
    input  SEG, AN, frame_tick
  );

  modport slave (
    input  Show, Leddata, countAll, Count_branch, countJmp,
    output SEG, AN, frame_tick
  );
endinterface

// File: rtl/seg7_scan_display_decode.sv
// Combinational nibble to active-low 7-segment pattern decoder.
module seg7_decode
  import seg7_scan_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  assign seg = hex_seg(nibble);

endmodule

// File: rtl/seg7_scan_display.sv
// Scans one of four CPU status words onto an 8-digit multiplexed display, taking
// a snapshot once per frame so digits never mix old and new values.
module seg7_scan_display
  import seg7_scan_display_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter bit BLANK_LZ = 1'b0
) (
  input  logic               clk,
  input  logic               clr,
  seg7_scan_display_if.slave bus
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       digit;
  logic [31:0]      shadow;
  logic             shadow_inv;
  logic             tick_q;
  logic [7:0]       an_q;
  logic [7:0]       seg_q;

  logic             slot_end;
  logic             frame_end;
  logic [31:0]      sel_word;
  logic             sel_inv;
  logic [3:0]       nibble;
  logic [7:0]       nib_seg;
  logic             lead_zero;
  logic [7:0]       an_next;
  logic [7:0]       seg_next;

  assign slot_end  = (div_cnt == DIV_LAST);
  assign frame_end = slot_end && (digit == 3'd7);

  always_comb begin
    sel_word = 32'h0;
    sel_inv  = 1'b0;
    case (bus.Show)
      SHOW_LED: sel_word = bus.Leddata;
      SHOW_ALL: sel_word = bus.countAll;
      SHOW_BR:  sel_word = bus.Count_branch;
      SHOW_JMP: sel_word = bus.countJmp;
      default:  sel_inv  = 1'b1;
    endcase
  end

  assign nibble = shadow[{digit, 2'b00} +: 4];

  seg7_decode u_decode (
    .nibble (nibble),
    .seg    (nib_seg)
  );

  // Digit 0 is never blanked; a dash frame overrides blanking so all 8 dashes show.
  assign lead_zero = BLANK_LZ && (digit != 3'd0) && !shadow_inv
                     && ((shadow >> {digit, 2'b00}) == 32'h0);

  assign an_next  = lead_zero ? 8'hFF : ~(8'b1 << digit);
  assign seg_next = shadow_inv ? SEG_DASH :
                    lead_zero  ? SEG_BLANK : nib_seg;

  always_ff @(posedge clk) begin
    if (clr) begin
      div_cnt    <= '0;
      digit      <= 3'd0;
      shadow     <= 32'h0;
      shadow_inv <= 1'b0;
      tick_q     <= 1'b0;
      an_q       <= 8'hFE;
      seg_q      <= 8'hC0;
    end else begin
      div_cnt <= slot_end ? '0 : div_cnt + 1'b1;
      if (slot_end) begin
        digit <= digit + 3'd1;
      end
      if (frame_end) begin
        shadow     <= sel_word;
        shadow_inv <= sel_inv;
      end
      tick_q <= frame_end;
      an_q   <= an_next;
      seg_q  <= seg_next;
    end
  end

  assign bus.AN         = an_q;
  assign bus.SEG        = seg_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display: two instances (leading-zero blanking off/on)
// share stimulus; expected frames are queued at stimulus time and checked per frame_tick.
module tb_seg7_scan_display;

  localparam int SCAN_DIV = 4;
  localparam int FRAME    = 8 * SCAN_DIV;
  localparam logic [7:0] HEX_TAB [0:15] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef struct packed {
    logic [31:0] word;
    logic        inv;
  } frame_t;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  seg7_scan_display_if bus0 ();
  seg7_scan_display_if bus1 ();

  seg7_scan_display #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b0)) dut0 (
    .clk (clk), .clr (clr), .bus (bus0)
  );
  seg7_scan_display #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b1)) dut1 (
    .clk (clk), .clr (clr), .bus (bus1)
  );

  frame_t      exp_q [$];
  int          n_pass  = 0;
  int          n_total = 0;
  bit          mon_en  = 1'b0;
  logic [2:0]  cur_show;
  logic [31:0] cur_led, cur_all, cur_br, cur_jmp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic set_inputs(input logic [2:0] show, input logic [31:0] led,
                            input logic [31:0] all, input logic [31:0] br,
                            input logic [31:0] jmp);
    cur_show = show; cur_led = led; cur_all = all; cur_br = br; cur_jmp = jmp;
    bus0.Show = show; bus0.Leddata = led; bus0.countAll = all;
    bus0.Count_branch = br; bus0.countJmp = jmp;
    bus1.Show = show; bus1.Leddata = led; bus1.countAll = all;
    bus1.Count_branch = br; bus1.countJmp = jmp;
  endtask

  // Reference: what the next snapshot should contain, from the bench's own record of inputs.
  function automatic frame_t cur_frame();
    frame_t f;
    f.inv = 1'b0;
    case (cur_show)
      3'd0: f.word = cur_led;
      3'd1: f.word = cur_all;
      3'd2: f.word = cur_br;
      3'd3: f.word = cur_jmp;
      default: begin f.word = 32'h0; f.inv = 1'b1; end
    endcase
    return f;
  endfunction

  function automatic bit model_lit(frame_t f, bit blz, int d);
    if (f.inv || !blz || d == 0) return 1'b1;
    return (f.word / (32'd1 << (4 * d))) != 32'd0;
  endfunction

  function automatic logic [7:0] model_an(frame_t f, bit blz, int d);
    return model_lit(f, blz, d) ? (8'hFF ^ (8'd1 << d)) : 8'hFF;
  endfunction

  function automatic logic [7:0] model_seg(frame_t f, bit blz, int d);
    logic [31:0] digit_val;
    if (f.inv) return 8'hBF;
    if (!model_lit(f, blz, d)) return 8'hFF;
    digit_val = (f.word / (32'd1 << (4 * d))) % 32'd16;
    return HEX_TAB[digit_val[3:0]];
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    return w >> $urandom_range(0, 31);
  endfunction

  task automatic wait_tick(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!bus0.frame_tick && cnt < FRAME + 8);
    if (!bus0.frame_tick) begin
      n_total++;
      $display("FAIL tick_timeout: no frame_tick within %0d cycles", cnt);
    end
  endtask

  // Monitor: each frame_tick pops one expected frame and checks all 32 display cycles.
  initial begin : monitor
    frame_t f;
    int     d;
    @(negedge clk);
    forever begin
      if (mon_en && bus0.frame_tick) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL scoreboard_empty: frame_tick with no expected frame at %0t", $time);
          f = '0;
        end else begin
          f = exp_q.pop_front();
        end
        check("tick_align", {31'd0, bus1.frame_tick}, 32'd1);
        for (int i = 0; i < FRAME; i++) begin
          @(negedge clk);
          if (mon_en) begin
            d = i / SCAN_DIV;
            check($sformatf("an_lz0_d%0d", d),  {24'd0, bus0.AN},  {24'd0, model_an(f, 1'b0, d)});
            check($sformatf("seg_lz0_d%0d", d), {24'd0, bus0.SEG}, {24'd0, model_seg(f, 1'b0, d)});
            check($sformatf("an_lz1_d%0d", d),  {24'd0, bus1.AN},  {24'd0, model_an(f, 1'b1, d)});
            if (model_lit(f, 1'b1, d))
              check($sformatf("seg_lz1_d%0d", d), {24'd0, bus1.SEG}, {24'd0, model_seg(f, 1'b1, d)});
          end
        end
      end else begin
        @(negedge clk);
      end
    end
  end

  initial begin : stimulus
    int cnt;
    int dly;
    clr = 1'b1;
    set_inputs(3'd0, 32'h1234ABCD, $urandom, $urandom, $urandom);
    repeat (2) @(negedge clk);
    check("rst_an0",   {24'd0, bus0.AN},  32'h000000FE);
    check("rst_seg0",  {24'd0, bus0.SEG}, 32'h000000C0);
    check("rst_tick0", {31'd0, bus0.frame_tick}, 32'd0);
    check("rst_an1",   {24'd0, bus1.AN},  32'h000000FE);
    check("rst_seg1",  {24'd0, bus1.SEG}, 32'h000000C0);
    check("rst_tick1", {31'd0, bus1.frame_tick}, 32'd0);

    exp_q.push_back(cur_frame());
    mon_en = 1'b1;
    clr    = 1'b0;
    wait_tick(cnt);
    check("first_tick_latency", cnt, 32'd32);

    for (int k = 0; k < 18; k++) begin
      dly = (k < 6) ? 13 : $urandom_range(1, 28);
      repeat (dly) @(negedge clk);
      case (k)
        0: set_inputs(3'd1, cur_led, 32'h0, cur_br, cur_jmp);
        1: set_inputs(3'd1, cur_led, 32'hFFFFFFFF, cur_br, cur_jmp);
        2: set_inputs(3'd5, cur_led, cur_all, cur_br, cur_jmp);
        3: set_inputs(3'd2, cur_led, cur_all, $urandom, cur_jmp);
        4: set_inputs(3'd3, cur_led, cur_all, cur_br, 32'h00000050);
        5: set_inputs(3'd3, cur_led, cur_all, cur_br, 32'h0);
        default: set_inputs(3'($urandom_range(0, 7)), rand_word(), rand_word(),
                            rand_word(), rand_word());
      endcase
      exp_q.push_back(cur_frame());
      wait_tick(cnt);
      check("frame_period", cnt, 32'(FRAME - dly));
    end

    // Inputs now stay constant, so the following frame repeats the last one.
    exp_q.push_back(cur_frame());
    repeat (FRAME + 8) @(negedge clk);
    mon_en = 1'b0;

    // Mid-frame reset at digit 5.
    wait_tick(cnt);
    repeat (21) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("midrst_an0",   {24'd0, bus0.AN},  32'h000000FE);
    check("midrst_seg0",  {24'd0, bus0.SEG}, 32'h000000C0);
    check("midrst_tick0", {31'd0, bus0.frame_tick}, 32'd0);
    check("midrst_an1",   {24'd0, bus1.AN},  32'h000000FE);
    check("midrst_seg1",  {24'd0, bus1.SEG}, 32'h000000C0);
    repeat (6) @(negedge clk);
    check("midrst_d1_an0",  {24'd0, bus0.AN},  32'h000000FD);
    check("midrst_d1_seg0", {24'd0, bus0.SEG}, 32'h000000C0);
    check("midrst_d1_an1",  {24'd0, bus1.AN},  32'h000000FF);
    wait_tick(cnt);
    check("midrst_tick_latency", cnt, 32'd26);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
